// File: rtl/pipeline_defs.sv
// Shared widths and entry layout for the register-file writeback path.
// A queued entry is {register index, value}, with the index in the MSBs.
package pipeline_defs;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 2;
   localparam int WB_DEPTH   = 4;
   localparam int ENTRY_W    = REG_ADDR_W + DATA_W;
endpackage

// File: rtl/wq_storage.sv
// Entry array for the writeback queue: two write ports, and every slot exposed
// so the top module can run the forwarding search over the whole array.
module wq_storage
   import pipeline_defs::*;
#(
   parameter int depth   = WB_DEPTH,
   parameter int entry_w = ENTRY_W
) (
   input  logic                              clk,
   input  logic [$clog2(depth)-1:0]          i_a_idx,
   input  logic [entry_w-1:0]                i_a_entry,
   input  logic                              i_a_en,
   input  logic [$clog2(depth)-1:0]          i_b_idx,
   input  logic [entry_w-1:0]                i_b_entry,
   input  logic                              i_b_en,
   output logic [depth-1:0][entry_w-1:0]     o_contents
);

   logic [depth-1:0][entry_w-1:0] r_mem;

   // The two indices always differ when both enables are set, so port order is irrelevant.
   always_ff @(posedge clk) begin
      if (i_a_en) r_mem[i_a_idx] <= i_a_entry;
      if (i_b_en) r_mem[i_b_idx] <= i_b_entry;
   end

   assign o_contents = r_mem;

endmodule

// File: rtl/regfile_write_queue.sv
// Writer-side front end of the register file: merges memory and ALU writeback
// results into a FIFO, drains one per cycle, and forwards queued values to decode.
module regfile_write_queue
   import pipeline_defs::*;
#(
   parameter int data_width = DATA_W,
   parameter int addr_width = REG_ADDR_W,
   parameter int depth      = WB_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [addr_width-1:0]     mem_addr,
   input  logic [data_width-1:0]     mem_data,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [addr_width-1:0]     alu_addr,
   input  logic [data_width-1:0]     alu_data,
   input  logic                      wr_stall,
   output logic                      wena,
   output logic [addr_width-1:0]     waddr,
   output logic [data_width-1:0]     wdata,
   input  logic [addr_width-1:0]     fwd_addr,
   output logic                      fwd_hit,
   output logic [data_width-1:0]     fwd_data,
   output logic [$clog2(depth):0]    count
);

   localparam int ptr_w   = $clog2(depth);
   localparam int cnt_w   = ptr_w + 1;
   localparam int entry_w = addr_width + data_width;

   logic [ptr_w-1:0]                 r_rd_ptr;
   logic [ptr_w-1:0]                 r_wr_ptr;
   logic [cnt_w-1:0]                 r_count;

   logic [cnt_w-1:0]                 w_free;
   logic                             w_mem_fire;
   logic                             w_alu_fire;
   logic [ptr_w-1:0]                 w_alu_idx;
   logic [cnt_w-1:0]                 w_enq_cnt;
   logic                             w_deq;
   logic [depth-1:0][entry_w-1:0]    w_contents;
   logic [entry_w-1:0]               w_head;
   logic [depth-1:0]                 w_match;
   logic [depth-1:0][data_width-1:0] w_slot_data;

   // Readies look only at the registered count, keeping valid off any ready path.
   assign w_free    = cnt_w'(depth) - r_count;
   assign mem_ready = (w_free >= cnt_w'(1));
   assign alu_ready = (w_free >= cnt_w'(2));

   assign w_mem_fire = mem_valid && mem_ready;
   assign w_alu_fire = alu_valid && alu_ready;
   assign w_alu_idx  = r_wr_ptr + ptr_w'(w_mem_fire);
   assign w_enq_cnt  = cnt_w'(w_mem_fire) + cnt_w'(w_alu_fire);
   assign w_deq      = (r_count != '0) && !wr_stall;

   wq_storage #(
      .depth   (depth),
      .entry_w (entry_w)
   ) u_storage (
      .clk        (clk),
      .i_a_idx    (r_wr_ptr),
      .i_a_entry  ({mem_addr, mem_data}),
      .i_a_en     (w_mem_fire),
      .i_b_idx    (w_alu_idx),
      .i_b_entry  ({alu_addr, alu_data}),
      .i_b_en     (w_alu_fire),
      .o_contents (w_contents)
   );

   assign w_head = w_contents[r_rd_ptr];
   assign wena   = w_deq;
   assign waddr  = (r_count != '0) ? w_head[entry_w-1 -: addr_width] : '0;
   assign wdata  = (r_count != '0) ? w_head[data_width-1:0] : '0;
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + ptr_w'(w_deq);
         r_wr_ptr <= r_wr_ptr + ptr_w'(w_enq_cnt);
         r_count  <= r_count + w_enq_cnt - cnt_w'(w_deq);
      end
   end

   // Slot gi is the gi-th oldest queued entry; only the first count slots are live.
   genvar gi;
   generate
      for (gi = 0; gi < depth; gi++) begin : g_fwd
         logic [entry_w-1:0] w_ent;
         assign w_ent           = w_contents[r_rd_ptr + ptr_w'(gi)];
         assign w_match[gi]     = (cnt_w'(gi) < r_count) &&
                                  (w_ent[entry_w-1 -: addr_width] == fwd_addr);
         assign w_slot_data[gi] = w_ent[data_width-1:0];
      end
   endgenerate

   // Walking oldest to youngest lets the youngest match overwrite earlier ones.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < depth; i++) begin
         if (w_match[i]) begin
            fwd_hit  = 1'b1;
            fwd_data = w_slot_data[i];
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scenario bench for regfile_write_queue: enqueues are pushed to a scoreboard,
// and each register-file write pops and checks the oldest expected entry.
module tb_regfile_write_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, alu_valid, wr_stall;
   logic        mem_ready, alu_ready;
   logic [1:0]  mem_addr, alu_addr, fwd_addr, waddr;
   logic [31:0] mem_data, alu_data, wdata, fwd_data;
   logic        wena, fwd_hit;
   logic [2:0]  count;

   int tests_run = 0;
   int failed    = 0;
   logic [33:0] sb[$];

   always #5 clk = ~clk;

   regfile_write_queue dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .wr_stall(wr_stall), .wena(wena), .waddr(waddr), .wdata(wdata),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
   );

   // Called just after a falling edge with inputs applied; returns after the next falling edge.
   task automatic step();
      logic [33:0] exp_e;
      #1;
      if (wena === 1'b1) begin
         tests_run++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL sb_write: write %0d/0x%08h with nothing expected", waddr, wdata);
         end else begin
            exp_e = sb.pop_front();
            if ({waddr, wdata} !== exp_e) begin
               failed++;
               $display("FAIL sb_write: got %0d/0x%08h, expected %0d/0x%08h",
                        waddr, wdata, exp_e[33:32], exp_e[31:0]);
            end else
               $display("[TB] write reg %0d <= 0x%08h", waddr, wdata);
         end
      end
      if (rst_n && mem_valid && mem_ready) sb.push_back({mem_addr, mem_data});
      if (rst_n && alu_valid && alu_ready) sb.push_back({alu_addr, alu_data});
      @(posedge clk);
      if (!rst_n) sb.delete();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_valid = 0; alu_valid = 0;
      mem_addr = 0; alu_addr = 0; mem_data = 0; alu_data = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; wr_stall = 0; fwd_addr = 2; idle_inputs();
      @(negedge clk);
      step(); step();
      rst_n = 1; #1;
      tests_run++;
      if ({count, wena, mem_ready, alu_ready, fwd_hit} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
         failed++;
         $display("FAIL reset: count=%0d wena=%b mr=%b ar=%b hit=%b, expected 0 0 1 1 0",
                  count, wena, mem_ready, alu_ready, fwd_hit);
      end else $display("[TB] reset state ok");
   endtask

   task automatic test_single_alu();
      alu_valid = 1; alu_addr = 2; alu_data = 32'hDEADBEEF;
      step();
      idle_inputs(); fwd_addr = 2; #1;
      tests_run++;
      if ({wena, waddr, wdata, fwd_hit, fwd_data, count} !==
          {1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 3'd1}) begin
         failed++;
         $display("FAIL single_alu: wena=%b waddr=%0d wdata=0x%08h hit=%b fdata=0x%08h count=%0d, expected 1 2 deadbeef 1 deadbeef 1",
                  wena, waddr, wdata, fwd_hit, fwd_data, count);
      end else $display("[TB] single alu head ok");
      step();
      tests_run++;
      if (count !== 3'd0) begin
         failed++; $display("FAIL single_alu_drain: count=%0d, expected 0", count);
      end else $display("[TB] single alu drained");
   endtask

   task automatic test_dual_order();
      logic [2:0]  exp_cnt [3] = '{3'd2, 3'd1, 3'd0};
      logic [1:0]  exp_adr [2] = '{2'd1, 2'd3};
      logic [31:0] exp_dat [2] = '{32'h11, 32'h33};
      mem_valid = 1; mem_addr = 1; mem_data = 32'h11;
      alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (count !== exp_cnt[i]) begin
            failed++; $display("FAIL dual_count[%0d]: count=%0d, expected %0d", i, count, exp_cnt[i]);
         end
         if (i < 2) begin
            tests_run++;
            if ({wena, waddr, wdata} !== {1'b1, exp_adr[i], exp_dat[i]}) begin
               failed++;
               $display("FAIL dual_head[%0d]: wena=%b %0d/0x%08h, expected 1 %0d/0x%08h",
                        i, wena, waddr, wdata, exp_adr[i], exp_dat[i]);
            end
            step();
         end
      end
   endtask

   task automatic test_stall_fill();
      // per cycle: mem offered?, expected count, mem_ready, alu_ready before the edge
      logic       offer_mem [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      logic       offer_alu [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [2:0] exp_cnt   [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
      logic       exp_mr    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp_ar    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      wr_stall = 1;
      for (int i = 0; i < 4; i++) begin
         mem_valid = offer_mem[i]; mem_addr = 2'(i);     mem_data = 32'h100 + i;
         alu_valid = offer_alu[i]; alu_addr = 2'(3 - i); alu_data = 32'h200 + i;
         #1;
         tests_run++;
         if ({count, mem_ready, alu_ready, wena} !== {exp_cnt[i], exp_mr[i], exp_ar[i], 1'b0}) begin
            failed++;
            $display("FAIL stall_fill[%0d]: count=%0d mr=%b ar=%b wena=%b, expected %0d %b %b 0",
                     i, count, mem_ready, alu_ready, wena, exp_cnt[i], exp_mr[i], exp_ar[i]);
         end else $display("[TB] stall cycle %0d count=%0d mr=%b ar=%b", i, count, mem_ready, alu_ready);
         step();
      end
      idle_inputs(); wr_stall = 0;
      for (int i = 4; i > 0; i--) begin
         #1;
         tests_run++;
         if ({count, wena} !== {3'(i), 1'b1}) begin
            failed++; $display("FAIL drain: count=%0d wena=%b, expected %0d 1", count, wena, i);
         end
         step();
      end
   endtask

   task automatic test_fwd_youngest();
      wr_stall = 1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_addr = 0; alu_data = 32'hA + i;
         step();
      end
      idle_inputs();
      fwd_addr = 0; #1;
      tests_run++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'hC}) begin
         failed++; $display("FAIL fwd_youngest: hit=%b data=0x%08h, expected 1 0x0000000c", fwd_hit, fwd_data);
      end else $display("[TB] fwd addr 0 -> 0x%08h", fwd_data);
      fwd_addr = 1; mem_valid = 1; mem_addr = 1; mem_data = 32'h77; #1;
      tests_run++;
      if (fwd_hit !== 1'b0) begin
         failed++; $display("FAIL fwd_miss: hit=%b, expected 0", fwd_hit);
      end else $display("[TB] fwd addr 1 miss (same-cycle input not forwarded)");
      idle_inputs();
      // Head still forwarded while it is written; B and C remain behind it.
      wr_stall = 0; fwd_addr = 0; #1;
      tests_run++;
      if ({wena, fwd_hit, fwd_data} !== {1'b1, 1'b1, 32'hC}) begin
         failed++; $display("FAIL fwd_during_write: wena=%b hit=%b data=0x%08h, expected 1 1 0x0000000c",
                            wena, fwd_hit, fwd_data);
      end
      step(); step(); step();
      tests_run++;
      if ({count, fwd_hit} !== {3'd0, 1'b0}) begin
         failed++; $display("FAIL fwd_empty: count=%0d hit=%b, expected 0 0", count, fwd_hit);
      end
   endtask

   task automatic test_reset_mid();
      wr_stall = 1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_addr = 2'(i); alu_data = 32'h5000 + i;
         step();
      end
      idle_inputs(); #1;
      tests_run++;
      if (count !== 3'd3) begin
         failed++; $display("FAIL reset_mid_fill: count=%0d, expected 3", count);
      end
      rst_n = 0;
      step();
      rst_n = 1; #1;
      tests_run++;
      if ({count, wena, mem_ready, alu_ready} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
         failed++; $display("FAIL reset_mid: count=%0d wena=%b mr=%b ar=%b, expected 0 0 1 1",
                            count, wena, mem_ready, alu_ready);
      end else $display("[TB] reset mid-operation cleared queue");
      wr_stall = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests_run++;
         if (wena !== 1'b0) begin
            failed++; $display("FAIL stale_write[%0d]: wena=%b waddr=%0d, expected wena 0", i, wena, waddr);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_dual_order();
      test_stall_fill();
      test_fwd_youngest();
      test_reset_mid();
      tests_run++;
      if (sb.size() != 0) begin
         failed++; $display("FAIL sb_leftover: %0d entries never written, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
